// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// 1-cycle hit latency. A miss requests one aligned block and refills the line.
// A flush during a miss lets the refill finish and drops only the response.
// Optional macro ICACHE_PERF_EN adds the hit_cnt/miss_cnt counter outputs.
module icache #(
    parameter int unsigned BLOCK_WIDTH = 1,
    parameter int unsigned CACHE_SIZE  = 8,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              rdy_in,
    input  logic                              IF2IC_en,
    input  logic [ADDR_WIDTH-1:0]             IF2IC_addr,
    output logic                              IC2IF_en,
    output logic [31:0]                       IC2IF_inst,
    input  logic                              IC_clear,
    output logic                              IC2MC_en,
    output logic [ADDR_WIDTH-1:0]             IC2MC_addr,
    input  logic                              MC2IC_en,
    input  logic [32*(1<<BLOCK_WIDTH)-1:0]    MC2IC_block
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                       hit_cnt,
    output logic [31:0]                       miss_cnt
`endif
);

    localparam int unsigned BLOCK_SIZE = 1 << BLOCK_WIDTH;
    localparam int unsigned BLOCK_NUM  = 1 << CACHE_SIZE;
    localparam int unsigned LINE_W     = 32 * BLOCK_SIZE;
    localparam int unsigned OFF_W      = BLOCK_WIDTH + 2;
    localparam int unsigned IDX_LSB    = BLOCK_WIDTH + 2;
    localparam int unsigned TAG_LSB    = CACHE_SIZE + BLOCK_WIDTH + 2;
    localparam int unsigned TAG_W      = ADDR_WIDTH - TAG_LSB;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                  state_q, state_n;
    logic [BLOCK_NUM-1:0]    valid_q;
    logic [TAG_W-1:0]        tag_arr  [BLOCK_NUM];
    logic [LINE_W-1:0]       data_arr [BLOCK_NUM];
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_n;
    logic                    discard_q, discard_n;

    logic                    if_en_n;
    logic [31:0]             inst_n;
    logic                    mc_en_n;
    logic [ADDR_WIDTH-1:0]   mc_addr_n;

    logic [ADDR_WIDTH-1:0]   lookup_addr_c;
    logic [CACHE_SIZE-1:0]   idx_c;
    logic [TAG_W-1:0]        tag_c;
    logic [BLOCK_WIDTH-1:0]  wsel_c;
    logic                    hit_c;
    logic [31:0]             hit_word_c;
    logic [31:0]             refill_word_c;
    logic                    line_we_c;
    logic                    hit_acc_c;
    logic                    miss_acc_c;
    logic                    unused_addr_lsb;

    // In MISS the latched request address drives the line index/tag/word select.
    assign lookup_addr_c   = (state_q == MISS) ? miss_addr_q : IF2IC_addr;
    assign idx_c           = lookup_addr_c[TAG_LSB-1:IDX_LSB];
    assign tag_c           = lookup_addr_c[ADDR_WIDTH-1:TAG_LSB];
    assign wsel_c          = lookup_addr_c[IDX_LSB-1:2];
    assign hit_c           = valid_q[idx_c] && (tag_arr[idx_c] == tag_c);
    assign hit_word_c      = data_arr[idx_c][{wsel_c, 5'b0} +: 32];
    assign refill_word_c   = MC2IC_block[{wsel_c, 5'b0} +: 32];
    assign unused_addr_lsb = ^lookup_addr_c[1:0];

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state_q;
        if_en_n     = 1'b0;
        inst_n      = IC2IF_inst;
        mc_en_n     = IC2MC_en;
        mc_addr_n   = IC2MC_addr;
        miss_addr_n = miss_addr_q;
        discard_n   = discard_q;
        line_we_c   = 1'b0;
        hit_acc_c   = 1'b0;
        miss_acc_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (IF2IC_en && !IC2IF_en && !IC_clear) begin
                    if (hit_c) begin
                        if_en_n   = 1'b1;
                        inst_n    = hit_word_c;
                        hit_acc_c = 1'b1;
                    end else begin
                        mc_en_n     = 1'b1;
                        mc_addr_n   = {IF2IC_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
                        miss_addr_n = IF2IC_addr;
                        state_n     = MISS;
                        miss_acc_c  = 1'b1;
                    end
                end
            end
            MISS: begin
                mc_en_n = 1'b1;
                if (IC_clear) begin
                    discard_n = 1'b1;
                end
                if (MC2IC_en) begin
                    line_we_c = 1'b1;
                    mc_en_n   = 1'b0;
                    discard_n = 1'b0;
                    state_n   = IDLE;
                    if (!discard_q && !IC_clear) begin
                        if_en_n = 1'b1;
                        inst_n  = refill_word_c;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state, valid bits and registered outputs; everything holds while rdy_in=0.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            discard_q   <= 1'b0;
            IC2IF_en    <= 1'b0;
            IC2IF_inst  <= '0;
            IC2MC_en    <= 1'b0;
            IC2MC_addr  <= '0;
        end else if (rdy_in) begin
            state_q     <= state_n;
            miss_addr_q <= miss_addr_n;
            discard_q   <= discard_n;
            IC2IF_en    <= if_en_n;
            IC2IF_inst  <= inst_n;
            IC2MC_en    <= mc_en_n;
            IC2MC_addr  <= mc_addr_n;
            if (line_we_c) begin
                valid_q[idx_c] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are not reset; valid bits guard them.
    always_ff @(posedge clk_in) begin
        if (rdy_in && line_we_c) begin
            tag_arr[idx_c]  <= tag_c;
            data_arr[idx_c] <= MC2IC_block;
        end
    end

`ifdef ICACHE_PERF_EN
    // Accepted-hit and miss-issue counters, wrapping modulo 2^32.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy_in) begin
            if (hit_acc_c) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_acc_c) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = hit_acc_c ^ miss_acc_c;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a table of fetches plus hand-written
// sequences for flush, back-to-back, rdy_in stall and async reset.
module tb_icache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        IF2IC_en;
    logic [31:0] IF2IC_addr;
    logic        IC2IF_en;
    logic [31:0] IC2IF_inst;
    logic        IC_clear;
    logic        IC2MC_en;
    logic [31:0] IC2MC_addr;
    logic        MC2IC_en;
    logic [63:0] MC2IC_block;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    icache dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .IF2IC_en    (IF2IC_en),
        .IF2IC_addr  (IF2IC_addr),
        .IC2IF_en    (IC2IF_en),
        .IC2IF_inst  (IC2IF_inst),
        .IC_clear    (IC_clear),
        .IC2MC_en    (IC2MC_en),
        .IC2MC_addr  (IC2MC_addr),
        .MC2IC_en    (MC2IC_en),
        .MC2IC_block (MC2IC_block)
`ifdef ICACHE_PERF_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        logic [63:0] blk;
        logic [31:0] mc_addr;
        logic [31:0] inst;
    } fetch_vec_t;

    fetch_vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One complete fetch; a miss is answered two cycles after the request appears.
    task automatic do_fetch(input string nm, input logic [31:0] addr, input logic hit,
                            input logic [63:0] blk, input logic [31:0] mc_addr,
                            input logic [31:0] inst);
        IF2IC_en   = 1'b1;
        IF2IC_addr = addr;
        tick();
        if (hit) begin
            check({nm, " hit_mc_en"}, 32'(IC2MC_en), 32'd0);
            check({nm, " hit_vld"}, 32'(IC2IF_en), 32'd1);
            check({nm, " hit_inst"}, IC2IF_inst, inst);
        end else begin
            check({nm, " miss_vld"}, 32'(IC2IF_en), 32'd0);
            check({nm, " miss_mc_en"}, 32'(IC2MC_en), 32'd1);
            check({nm, " miss_mc_addr"}, IC2MC_addr, mc_addr);
            tick();
            check({nm, " mc_en_hold"}, 32'(IC2MC_en), 32'd1);
            MC2IC_en    = 1'b1;
            MC2IC_block = blk;
            tick();
            MC2IC_en = 1'b0;
            check({nm, " refill_vld"}, 32'(IC2IF_en), 32'd1);
            check({nm, " refill_inst"}, IC2IF_inst, inst);
            check({nm, " mc_en_drop"}, 32'(IC2MC_en), 32'd0);
        end
        IF2IC_en = 1'b0;
        tick();
        check({nm, " vld_pulse"}, 32'(IC2IF_en), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 1'b0, 64'h11223344_AABBCCDD, 32'h0000_0000, 32'hAABBCCDD};
        vecs[1] = '{32'h0000_0004, 1'b1, 64'h0,                 32'h0,         32'h11223344};
        vecs[2] = '{32'h0000_0800, 1'b0, 64'h55667788_99AA0011, 32'h0000_0800, 32'h99AA0011};
        vecs[3] = '{32'h0000_0000, 1'b0, 64'h11223344_AABBCCDD, 32'h0000_0000, 32'hAABBCCDD};
        vecs[4] = '{32'h0000_080C, 1'b0, 64'hCAFEF00D_0BADBEEF, 32'h0000_0808, 32'hCAFEF00D};
        vecs[5] = '{32'h0000_0808, 1'b1, 64'h0,                 32'h0,         32'h0BADBEEF};
        vecs[6] = '{32'h0000_0004, 1'b1, 64'h0,                 32'h0,         32'h11223344};

        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        IF2IC_en    = 1'b0;
        IF2IC_addr  = '0;
        IC_clear    = 1'b0;
        MC2IC_en    = 1'b0;
        MC2IC_block = '0;
        tick();
        tick();
        check("rst IC2IF_en", 32'(IC2IF_en), 32'd0);
        check("rst IC2IF_inst", IC2IF_inst, 32'd0);
        check("rst IC2MC_en", 32'(IC2MC_en), 32'd0);
        check("rst IC2MC_addr", IC2MC_addr, 32'd0);
        rst_in = 1'b0;
        tick();
        check("idle IC2MC_en", 32'(IC2MC_en), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hit, vecs[i].blk,
                     vecs[i].mc_addr, vecs[i].inst);
        end

        // Request held while IC2IF_en=1 is ignored that cycle and accepted the next.
        IF2IC_en   = 1'b1;
        IF2IC_addr = 32'h0000_0004;
        tick();
        check("b2b first_vld", 32'(IC2IF_en), 32'd1);
        check("b2b first_inst", IC2IF_inst, 32'h11223344);
        IF2IC_addr = 32'h0000_0808;
        tick();
        check("b2b gap_vld", 32'(IC2IF_en), 32'd0);
        tick();
        check("b2b second_vld", 32'(IC2IF_en), 32'd1);
        check("b2b second_inst", IC2IF_inst, 32'h0BADBEEF);
        IF2IC_en = 1'b0;
        tick();

        // Flush in IDLE suppresses a hit; the request is taken once clear drops.
        IF2IC_en   = 1'b1;
        IF2IC_addr = 32'h0000_0000;
        IC_clear   = 1'b1;
        tick();
        check("idle_flush vld", 32'(IC2IF_en), 32'd0);
        check("idle_flush mc_en", 32'(IC2MC_en), 32'd0);
        IC_clear = 1'b0;
        tick();
        check("idle_flush after_vld", 32'(IC2IF_en), 32'd1);
        check("idle_flush after_inst", IC2IF_inst, 32'hAABBCCDD);
        IF2IC_en = 1'b0;
        tick();

        // Flush two cycles into a miss: refill completes, no response.
        IF2IC_en   = 1'b1;
        IF2IC_addr = 32'h0000_0100;
        tick();
        check("miss_flush mc_en", 32'(IC2MC_en), 32'd1);
        check("miss_flush mc_addr", IC2MC_addr, 32'h0000_0100);
        tick();
        IC_clear = 1'b1;
        IF2IC_en = 1'b0;
        tick();
        IC_clear = 1'b0;
        check("miss_flush mc_en_kept", 32'(IC2MC_en), 32'd1);
        tick();
        MC2IC_en    = 1'b1;
        MC2IC_block = 64'h12345678_DEADBEEF;
        tick();
        MC2IC_en = 1'b0;
        check("miss_flush no_vld", 32'(IC2IF_en), 32'd0);
        check("miss_flush mc_en_drop", 32'(IC2MC_en), 32'd0);
        tick();
        check("miss_flush still_no_vld", 32'(IC2IF_en), 32'd0);
        do_fetch("miss_flush refetch", 32'h0000_0100, 1'b1, 64'h0, 32'h0, 32'hDEADBEEF);

        // MC2IC_en and IC_clear together: line written, response dropped.
        IF2IC_en   = 1'b1;
        IF2IC_addr = 32'h0000_0200;
        tick();
        check("simul mc_en", 32'(IC2MC_en), 32'd1);
        MC2IC_en    = 1'b1;
        IC_clear    = 1'b1;
        IF2IC_en    = 1'b0;
        MC2IC_block = 64'h0F0F0F0F_F0F0F0F0;
        tick();
        MC2IC_en = 1'b0;
        IC_clear = 1'b0;
        check("simul no_vld", 32'(IC2IF_en), 32'd0);
        check("simul mc_en_drop", 32'(IC2MC_en), 32'd0);
        do_fetch("simul refetch", 32'h0000_0204, 1'b1, 64'h0, 32'h0, 32'h0F0F0F0F);

        // rdy_in low for 5 cycles mid-miss: everything holds.
        IF2IC_en   = 1'b1;
        IF2IC_addr = 32'h0000_0300;
        tick();
        check("stall mc_en", 32'(IC2MC_en), 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall%0d mc_en", i), 32'(IC2MC_en), 32'd1);
            check($sformatf("stall%0d mc_addr", i), IC2MC_addr, 32'h0000_0300);
            check($sformatf("stall%0d vld", i), 32'(IC2IF_en), 32'd0);
        end
        rdy_in = 1'b1;
        tick();
        check("stall resume_mc_en", 32'(IC2MC_en), 32'd1);
        MC2IC_en    = 1'b1;
        MC2IC_block = 64'h76543210_89ABCDEF;
        tick();
        MC2IC_en = 1'b0;
        check("stall refill_vld", 32'(IC2IF_en), 32'd1);
        check("stall refill_inst", IC2IF_inst, 32'h89ABCDEF);
        check("stall mc_en_drop", 32'(IC2MC_en), 32'd0);
        IF2IC_en = 1'b0;
        tick();

        // Async reset mid-miss clears outputs at once and invalidates all lines.
        IF2IC_en   = 1'b1;
        IF2IC_addr = 32'h0000_0400;
        tick();
        check("areset pre_mc_en", 32'(IC2MC_en), 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        check("areset mc_en", 32'(IC2MC_en), 32'd0);
        check("areset mc_addr", IC2MC_addr, 32'd0);
        check("areset vld", 32'(IC2IF_en), 32'd0);
        IF2IC_en = 1'b0;
        tick();
        rst_in = 1'b0;
        do_fetch("areset refetch", 32'h0000_0000, 1'b0, 64'h11223344_AABBCCDD,
                 32'h0000_0000, 32'hAABBCCDD);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the instruction fetcher and the memory controller.
- Serves 32-bit instruction fetches. On a miss it requests one aligned block from the memory controller (IC2MC_addr/IC2MC_en) and refills from MC2IC_block/MC2IC_en.
- Supports a flush from the commit stage, which drops a pending fetch response without corrupting the memory-controller handshake.

Parameters:
- BLOCK_WIDTH, 1: log2(words per line).
- BLOCK_SIZE, 1<<BLOCK_WIDTH: words per line.
- CACHE_SIZE, 8: log2(number of lines).
- BLOCK_NUM, 1<<CACHE_SIZE: number of lines.
- ADDR_WIDTH, 32: address width.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- rdy_in  in  1  global enable; when 0, all state and outputs hold.
- IF2IC_en  in  1  fetch request, held with a stable address until IC2IF_en.
- IF2IC_addr  in  ADDR_WIDTH  fetch PC, word aligned.
- IC2IF_en  out  1  one-cycle response valid.
- IC2IF_inst  out  32  instruction word.
- IC_clear  in  1  flush: abandon the current fetch.
- IC2MC_en  out  1  block request, held until MC2IC_en.
- IC2MC_addr  out  ADDR_WIDTH  block-aligned refill address.
- MC2IC_en  in  1  one-cycle refill-done pulse.
- MC2IC_block  in  32*BLOCK_SIZE  refill data, byte k of the block at bits [8k+7:8k] (little-endian).

Behaviour:
- Address split:
  - offset = addr[BLOCK_WIDTH+1:0]
  - word select = addr[BLOCK_WIDTH+1:2]
  - index = addr[CACHE_SIZE+BLOCK_WIDTH+1:BLOCK_WIDTH+2]
  - tag = remaining upper bits
- Storage: valid[BLOCK_NUM], tag array, data array. Only valid bits and control registers are reset; the data and tag arrays are not.
- Reset (async): state=IDLE, all valid=0, IC2IF_en=0, IC2IF_inst=0, IC2MC_en=0, IC2MC_addr=0, discard=0.
- States: IDLE, MISS.
- IDLE:
  - IC2IF_en is cleared every cycle unless set below.
  - A request is accepted only when IF2IC_en=1, IC2IF_en=0 and IC_clear=0.
  - Hit (valid[index] and tag match): next cycle IC2IF_en=1 for one cycle, IC2IF_inst = selected word. Stay IDLE. Hit latency is 1 cycle.
  - Miss: next cycle IC2MC_en=1, IC2MC_addr = addr with offset bits zeroed, state=MISS, request address latched internally.
- MISS:
  - IC2MC_en stays 1 until the cycle MC2IC_en=1 is sampled.
  - In that cycle the line is written (data, tag, valid=1), and at the following edge IC2MC_en=0 and state=IDLE.
  - In the same edge, IC2IF_en=1 and IC2IF_inst = word from MC2IC_block, unless discard=1.
  - Miss latency from MC2IC_en to IC2IF_en is 1 cycle.
  - IC2MC_en is never high in the cycle after MC2IC_en, so the memory controller never re-issues a request.
- Flush (IC_clear=1, rdy_in=1):
  - In IDLE: any IC2IF_en that would be produced at this edge is suppressed; the request is not accepted.
  - In MISS: the memory request cannot be aborted. discard is set, the refill still completes and writes the line, no IC2IF_en is generated, and discard is cleared on return to IDLE.
- Simultaneous MC2IC_en and IC_clear in MISS: line written, response suppressed.
- A request arriving while IC2IF_en=1 is ignored that cycle and accepted on the next cycle, so hit throughput is one fetch per 2 cycles.
- rdy_in=0: no state, array or output changes. MC2IC_en is held asserted by the memory controller only under rdy_in=1, so the cache samples it only when rdy_in=1.

Optional Feature:
- Macro ICACHE_PERF_EN.
- When defined: extra output ports hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
  - hit_cnt increments on each accepted hit; miss_cnt on each IDLE→MISS transition.
  - Both wrap modulo 2^32 and are unaffected by IC_clear.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
Default parameters: word select = addr[2], index = addr[10:3].
1. Cold fetch 0x0000_0000 → IC2MC_en=1 with IC2MC_addr=0x0; MC returns block 0x11223344_AABBCCDD → IC2IF_inst=0xAABBCCDD one cycle after MC2IC_en; IC2MC_en=0 in that cycle.
2. Follow-up fetch 0x0000_0004 → hit, no IC2MC_en, IC2IF_inst=0x11223344 one cycle after acceptance.
3. Conflict: fetch 0x0000_0800 (same index 0, different tag) → miss to 0x800; then refetch 0x0 → miss again (line evicted).
4. Flush during miss: fetch 0x100, pulse IC_clear two cycles later, MC2IC_en later → no IC2IF_en; refetch 0x100 → hit with the refilled data.
5. rdy_in=0 for 5 cycles while in MISS, MC2IC_en held 0 → IC2MC_en stays 1, no state change; resumes correctly.
6. Async reset asserted mid-MISS → outputs 0 immediately; after release, fetch of the same address misses (valid cleared).
